// File: rtl/cve2_obi_mem_responder_if.sv
// req/gnt/rvalid memory port bundle between a core-side master and a memory responder.
interface cve2_obi_mem_responder_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/cve2_obi_mem_responder.sv
// Memory-side responder for a req/gnt/rvalid port: word reads, byte-enabled writes,
// fixed-latency in-order responses, configurable grant stall and outstanding limit.
module cve2_obi_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] AddrBase       = 32'h0000_0000,
    parameter int unsigned GntStall       = 0,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter string       MemInitFile    = ""
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    cve2_obi_mem_responder_if.slave        bus,
    output logic                           busy_o
);
    localparam int unsigned IdxW   = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int unsigned OutW   = $clog2(MaxOutstanding + 1);
    localparam int unsigned StallW = (GntStall > 0) ? $clog2(GntStall + 1) : 1;

    logic [31:0]     mem [MemWords];
    logic [29:0]     word_off;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic            stall_ok;
    logic            accept;
    logic            retire;
    logic [OutW-1:0] out_q;
    logic [OutW-1:0] out_d;
    logic            busy_q;
    logic            pipe_valid [RespLatency];
    logic [31:0]     pipe_rdata [RespLatency];
    logic            pipe_err   [RespLatency];

    // Address decode relative to AddrBase; byte offset bits are dropped.
    assign word_off = 30'((bus.addr - AddrBase) >> 2);
    assign in_range = (bus.addr >= AddrBase) && (32'(word_off) < 32'(MemWords));
    assign idx      = IdxW'(word_off);

    assign bus.gnt = rst_ni && bus.req && stall_ok && (out_q < OutW'(MaxOutstanding));
    assign accept  = bus.gnt;
    assign retire  = pipe_valid[RespLatency-1];

    // Grant stall: req must be held GntStall cycles before gnt may rise.
    if (GntStall == 0) begin : g_no_stall
        assign stall_ok = 1'b1;
    end else begin : g_stall
        logic [StallW-1:0] stall_q;

        always_ff @(posedge clk_i) begin
            if (!rst_ni || !bus.req || accept) begin
                stall_q <= '0;
            end else if (!stall_ok) begin
                stall_q <= stall_q + StallW'(1);
            end
        end

        assign stall_ok = (stall_q == StallW'(GntStall));
    end

    always_comb begin
        out_d = out_q;
        if (accept && !retire) begin
            out_d = out_q + OutW'(1);
        end else if (retire && !accept) begin
            out_d = out_q - OutW'(1);
        end
    end

    // Outstanding count and response pipe; stage 0 is loaded on the accept edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q  <= '0;
            busy_q <= 1'b0;
            for (int unsigned i = 0; i < RespLatency; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_rdata[i] <= '0;
                pipe_err[i]   <= 1'b0;
            end
        end else begin
            out_q         <= out_d;
            busy_q        <= (out_d != '0);
            pipe_valid[0] <= accept;
            pipe_rdata[0] <= (accept && !bus.we && in_range) ? mem[idx] : 32'h0;
            pipe_err[0]   <= accept && !in_range;
            for (int unsigned i = 1; i < RespLatency; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    // Array is never reset; it survives rst_ni so data written earlier stays readable.
    always_ff @(posedge clk_i) begin
        if (accept && bus.we && in_range) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (bus.be[k]) begin
                    mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.rvalid = pipe_valid[RespLatency-1];
    assign bus.rdata  = pipe_rdata[RespLatency-1];
    assign bus.err    = pipe_err[RespLatency-1];
    assign busy_o     = busy_q;

`ifndef SYNTHESIS
    // A limit of RespLatency+1 lets a one-deep pipe stream back to back; beyond that is never reached.
    if (RespLatency < 1 || MaxOutstanding < 1 || MaxOutstanding > RespLatency + 1) begin : g_bad_params
        $error("cve2_obi_mem_responder: illegal RespLatency/MaxOutstanding combination");
    end

    req_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.req && !bus.gnt) |=> $stable({bus.addr, bus.we, bus.be, bus.wdata}));

    out_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_q <= OutW'(MaxOutstanding));
`endif

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// Scoreboard bench: three responder configurations (defaults, grant stall, deep pipe).
module tb_cve2_obi_mem_responder;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy_a, busy_b, busy_c;
    int   n_checks = 0;
    int   n_fail   = 0;

    resp_t exp_a[$];
    resp_t exp_b[$];
    resp_t exp_c[$];
    resp_t ra, rb, rc;

    always #5 clk = ~clk;

    cve2_obi_mem_responder_if ifa ();
    cve2_obi_mem_responder_if ifb ();
    cve2_obi_mem_responder_if ifc ();

    cve2_obi_mem_responder u_dut_a (
        .clk_i (clk), .rst_ni (rst_n), .bus (ifa), .busy_o (busy_a)
    );

    cve2_obi_mem_responder #(.GntStall(2)) u_dut_b (
        .clk_i (clk), .rst_ni (rst_n), .bus (ifb), .busy_o (busy_b)
    );

    cve2_obi_mem_responder #(.RespLatency(3), .MaxOutstanding(2)) u_dut_c (
        .clk_i (clk), .rst_ni (rst_n), .bus (ifc), .busy_o (busy_c)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitors: every rvalid must match the head of its expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifa.rvalid === 1'b1) begin
            if (exp_a.size() == 0) begin
                check_val("a_spurious_rvalid", 32'(1), 32'(0));
            end else begin
                ra = exp_a.pop_front();
                check_val("a_rdata", ifa.rdata, ra.rdata);
                check_val("a_err", 32'(ifa.err), 32'(ra.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifb.rvalid === 1'b1) begin
            if (exp_b.size() == 0) begin
                check_val("b_spurious_rvalid", 32'(1), 32'(0));
            end else begin
                rb = exp_b.pop_front();
                check_val("b_rdata", ifb.rdata, rb.rdata);
                check_val("b_err", 32'(ifb.err), 32'(rb.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc.rvalid === 1'b1) begin
            if (exp_c.size() == 0) begin
                check_val("c_spurious_rvalid", 32'(1), 32'(0));
            end else begin
                rc = exp_c.pop_front();
                check_val("c_rdata", ifc.rdata, rc.rdata);
                check_val("c_err", 32'(ifc.err), 32'(rc.err));
            end
        end
    end

    // Single access on the default instance: gnt same cycle, rvalid one cycle later.
    task automatic a_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] er, input logic ee);
        int n;
        n = 0;
        @(negedge clk);
        ifa.req = 1'b1; ifa.we = we; ifa.addr = addr; ifa.be = be; ifa.wdata = wdata;
        #1;
        while (ifa.gnt !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check_val("a_gnt_same_cycle", 32'(n), 32'(0));
        if (ifa.gnt === 1'b1) exp_a.push_back('{rdata: er, err: ee});
        @(posedge clk); #1;
        ifa.req = 1'b0;
        @(negedge clk);
        check_val("a_rvalid_latency", 32'(ifa.rvalid), 32'(1));
        check_val("a_busy_inflight", 32'(busy_a), 32'(1));
        @(negedge clk);
        check_val("a_idle_rvalid", 32'(ifa.rvalid), 32'(0));
        check_val("a_idle_rdata", ifa.rdata, 32'h0);
        check_val("a_idle_busy", 32'(busy_a), 32'(0));
    endtask

    task automatic c_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] er);
        int n;
        n = 0;
        @(negedge clk);
        ifc.req = 1'b1; ifc.we = we; ifc.addr = addr; ifc.be = 4'hF; ifc.wdata = wdata;
        #1;
        while (ifc.gnt !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check_val("c_gnt_seen", 32'(ifc.gnt), 32'(1));
        if (ifc.gnt === 1'b1) exp_c.push_back('{rdata: er, err: 1'b0});
        @(posedge clk); #1;
        ifc.req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] gm;
        logic [9:0] rm;
        int         k;
        int         n;
        int         rv_cnt;

        rst_n = 1'b0;
        ifa.req = 1'b1; ifa.we = 1'b0; ifa.addr = 32'h0; ifa.be = 4'hF; ifa.wdata = 32'h0;
        ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = 32'h0; ifb.be = 4'hF; ifb.wdata = 32'h0;
        ifc.req = 1'b0; ifc.we = 1'b0; ifc.addr = 32'h0; ifc.be = 4'hF; ifc.wdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_gnt_low", 32'(ifa.gnt), 32'(0));
        check_val("rst_rvalid", 32'(ifa.rvalid), 32'(0));
        check_val("rst_rdata", ifa.rdata, 32'h0);
        check_val("rst_err", 32'(ifa.err), 32'(0));
        check_val("rst_busy", 32'(busy_a), 32'(0));
        check_val("rst_c_rvalid", 32'(ifc.rvalid), 32'(0));
        ifa.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Full write then read back; then partial byte write.
        a_access(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        a_access(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);
        a_access(1'b1, 32'h10, 4'b0001, 32'h0000_00AA, 32'h0, 1'b0);
        a_access(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEAA, 1'b0);

        // Range boundary: last word in range, first word past the array.
        a_access(1'b1, 32'h0FFC, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        a_access(1'b0, 32'h1000, 4'hF, 32'h0, 32'h0, 1'b1);
        a_access(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        a_access(1'b0, 32'h0FFC, 4'hF, 32'h0, 32'h1234_5678, 1'b0);

        // Grant stall of 2; dropping req restarts the count.
        @(negedge clk);
        ifb.req = 1'b1; ifb.we = 1'b1; ifb.addr = 32'h40; ifb.be = 4'hF; ifb.wdata = 32'h0000_0055;
        #1 check_val("b_c0_gnt", 32'(ifb.gnt), 32'(0));
        @(negedge clk);
        ifb.req = 1'b0;
        #1 check_val("b_drop_gnt", 32'(ifb.gnt), 32'(0));
        @(negedge clk);
        ifb.req = 1'b1;
        #1 check_val("b_restart_c0", 32'(ifb.gnt), 32'(0));
        @(negedge clk); #1 check_val("b_restart_c1", 32'(ifb.gnt), 32'(0));
        @(negedge clk); #1 check_val("b_restart_c2", 32'(ifb.gnt), 32'(1));
        if (ifb.gnt === 1'b1) exp_b.push_back('{rdata: 32'h0, err: 1'b0});
        @(posedge clk); #1;
        ifb.req = 1'b0;
        @(negedge clk);
        ifb.req = 1'b1; ifb.we = 1'b0;
        n = 0;
        #1;
        while (ifb.gnt !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check_val("b_read_stall_cycles", 32'(n), 32'(2));
        if (ifb.gnt === 1'b1) exp_b.push_back('{rdata: 32'h0000_0055, err: 1'b0});
        @(posedge clk); #1;
        ifb.req = 1'b0;

        // Deep pipe: preload four words, then stream four reads with req held.
        for (int i = 0; i < 4; i++) c_access(1'b1, 32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 32'h0);
        repeat (6) @(negedge clk);
        gm = '0;
        rm = '0;
        k  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ifc.req = 1'b1; ifc.we = 1'b0; ifc.addr = 32'h100;
            end
            #1;
            rm[i] = ifc.rvalid;
            gm[i] = ifc.gnt;
            if (ifc.gnt === 1'b1) begin
                exp_c.push_back('{rdata: 32'hC0DE_0000 + 32'(k), err: 1'b0});
                k++;
                @(posedge clk); #1;
                if (k < 4) ifc.addr = 32'h100 + 32'(4*k);
                else ifc.req = 1'b0;
            end
        end
        check_val("c_gnt_pattern", 32'(gm), 32'(10'b00_0011_0011));
        check_val("c_rvalid_pattern", 32'(rm), 32'(10'b01_1001_1000));
        repeat (4) @(negedge clk);
        check_val("c_busy_drained", 32'(busy_c), 32'(0));

        // Reset one cycle after two accepts: in-flight responses are dropped.
        @(negedge clk);
        ifc.req = 1'b1; ifc.we = 1'b0; ifc.addr = 32'h100;
        #1 check_val("c6_accept0", 32'(ifc.gnt), 32'(1));
        @(posedge clk); #1;
        ifc.addr = 32'h104;
        @(negedge clk); #1 check_val("c6_accept1", 32'(ifc.gnt), 32'(1));
        @(posedge clk); #1;
        ifc.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifc.rvalid === 1'b1) rv_cnt++;
        end
        check_val("c6_no_rvalid_after_reset", 32'(rv_cnt), 32'(0));
        check_val("c6_busy_after_reset", 32'(busy_c), 32'(0));
        c_access(1'b0, 32'h108, 32'h0, 32'hC0DE_0002);
        a_access(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEAA, 1'b0);

        repeat (8) @(negedge clk);
        check_val("a_queue_empty", 32'(exp_a.size()), 32'(0));
        check_val("b_queue_empty", 32'(exp_b.size()), 32'(0));
        check_val("c_queue_empty", 32'(exp_c.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
